// File: rtl/dram_responder_pkg.sv
// Shared definitions for the DRAM responder: state encodings, default
// access latency and the width of the latency down-counter.
package dram_responder_pkg;

    typedef enum logic [1:0] {
        DRAM_STATE_IDLE    = 2'd0,
        DRAM_STATE_ACCESS  = 2'd1,
        DRAM_STATE_ACK     = 2'd2,
        DRAM_STATE_RELEASE = 2'd3
    } dram_state_t;

    localparam int DRAM_DEFAULT_LATENCY = 10;
    localparam int DRAM_COUNT_W         = 8;

endpackage

// File: rtl/dram_responder_array.sv
// Block storage for the DRAM responder: single port, synchronous write,
// combinational read. Contents are deliberately never reset so that data
// survives a reset of the access state machine.
module dram_responder_array #(
    parameter int DEPTH       = 256,
    parameter int BLOCK_WIDTH = 128,
    parameter int IDX_W       = 8
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [IDX_W-1:0]       idx,
    input  logic [BLOCK_WIDTH-1:0] wdata,
    output logic [BLOCK_WIDTH-1:0] rdata
);

    logic [BLOCK_WIDTH-1:0] mem [DEPTH];

    // Commit one block per write strobe.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dram_responder.sv
// Fixed-latency DRAM model answering block reads/writes from an L1
// controller. A request is latched on acceptance, counted down for
// LATENCY cycles, acknowledged with a one-cycle pulse, and the strobe must
// then be released before another request is taken.
module dram_responder
    import dram_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int BLOCK_WIDTH = 128,
    parameter int DEPTH       = 256,
    parameter int LATENCY     = DRAM_DEFAULT_LATENCY
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   dram_cs,
    input  logic                   dram_we,
    input  logic [ADDR_WIDTH-1:0]  dram_addr,
    input  logic [BLOCK_WIDTH-1:0] dram_data_i,
    output logic [BLOCK_WIDTH-1:0] dram_data_o,
    output logic                   dram_ack
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BLK_W = ADDR_WIDTH - 4;
    localparam logic [DRAM_COUNT_W-1:0] COUNT_LOAD = DRAM_COUNT_W'(LATENCY - 1);

    dram_state_t              state_reg;
    logic [DRAM_COUNT_W-1:0]  count_reg;
    logic                     we_reg;
    logic [BLK_W-1:0]         blk_reg;
    logic [BLOCK_WIDTH-1:0]   data_reg;

    logic [IDX_W-1:0]         blk_idx;
    logic [BLOCK_WIDTH-1:0]   rd_data;
    logic                     access_done;
    logic                     array_we;
    logic                     unused_addr_bits;

    // Byte offset within a block carries no meaning for this memory.
    assign unused_addr_bits = ^dram_addr[3:0];

    // Block number wraps modulo the number of stored blocks.
    assign blk_idx = IDX_W'(blk_reg % BLK_W'(DEPTH));

    // The final ACCESS cycle; the write lands on the same edge that enters ACK.
    assign access_done = (state_reg == DRAM_STATE_ACCESS) && (count_reg == '0);
    assign array_we    = rst && access_done && we_reg;

    dram_responder_array #(
        .DEPTH       (DEPTH),
        .BLOCK_WIDTH (BLOCK_WIDTH),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (array_we),
        .idx   (blk_idx),
        .wdata (data_reg),
        .rdata (rd_data)
    );

    // Request sequencing with registered ack and read-data outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= DRAM_STATE_IDLE;
            count_reg   <= '0;
            dram_ack    <= 1'b0;
            dram_data_o <= '0;
        end else begin
            dram_ack <= 1'b0;
            case (state_reg)
                DRAM_STATE_IDLE: begin
                    if (dram_cs) begin
                        we_reg    <= dram_we;
                        blk_reg   <= dram_addr[ADDR_WIDTH-1:4];
                        data_reg  <= dram_data_i;
                        count_reg <= COUNT_LOAD;
                        state_reg <= DRAM_STATE_ACCESS;
                    end
                end
                DRAM_STATE_ACCESS: begin
                    if (count_reg == '0) begin
                        state_reg <= DRAM_STATE_ACK;
                        dram_ack  <= 1'b1;
                        if (!we_reg) begin
                            dram_data_o <= rd_data;
                        end
                    end else begin
                        count_reg <= count_reg - 1'b1;
                    end
                end
                DRAM_STATE_ACK: begin
                    state_reg <= DRAM_STATE_RELEASE;
                end
                DRAM_STATE_RELEASE: begin
                    if (!dram_cs) begin
                        state_reg <= DRAM_STATE_IDLE;
                    end
                end
                default: begin
                    state_reg <= DRAM_STATE_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dram_responder.sv
// Self-checking bench for dram_responder: directed scenarios followed by
// random traffic, compared against a plain block-array model.
module tb_dram_responder;

    localparam int AW    = 32;
    localparam int BW    = 128;
    localparam int DEP   = 256;
    localparam int LAT   = 10;
    localparam int LIMIT = 300;

    logic           clk;
    logic           rst;
    logic           dram_cs;
    logic           dram_we;
    logic [AW-1:0]  dram_addr;
    logic [BW-1:0]  dram_data_i;
    logic [BW-1:0]  dram_data_o;
    logic           dram_ack;

    logic [BW-1:0]  model_mem [DEP];
    logic [BW-1:0]  last_read;
    int             checks;
    int             failures;

    dram_responder #(
        .ADDR_WIDTH  (AW),
        .BLOCK_WIDTH (BW),
        .DEPTH       (DEP),
        .LATENCY     (LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .dram_cs     (dram_cs),
        .dram_we     (dram_we),
        .dram_addr   (dram_addr),
        .dram_data_i (dram_data_i),
        .dram_data_o (dram_data_o),
        .dram_ack    (dram_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned blk(input logic [AW-1:0] a);
        return (int'(a / 16)) % DEP;
    endfunction

    function automatic logic [BW-1:0] rand_block();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full request: accept, wait for ack, check it, hold cs, release.
    task automatic do_txn(input bit we, input logic [AW-1:0] addr, input logic [BW-1:0] data,
                          input int hold, input bit scramble, input bit drop);
        int cyc;
        logic [BW-1:0] exp_o;
        dram_cs     = 1'b1;
        dram_we     = we;
        dram_addr   = addr;
        dram_data_i = data;
        tick();
        cyc = 0;
        while (dram_ack !== 1'b1 && cyc < LIMIT) begin
            if (scramble) begin
                dram_addr   = $urandom;
                dram_data_i = rand_block();
                dram_we     = 1'($urandom_range(0, 1));
            end
            if (drop) dram_cs = 1'b0;
            tick();
            cyc++;
        end
        check("ack_latency", BW'(cyc), BW'(LAT));
        if (we) begin
            check("data_o_hold_on_write", dram_data_o, last_read);
            model_mem[blk(addr)] = data;
        end else begin
            exp_o = model_mem[blk(addr)];
            check("read_data", dram_data_o, exp_o);
            last_read = exp_o;
        end
        $display("txn we=%0d addr=%h blk=%0d lat=%0d data_o=%h", we, addr, blk(addr), cyc, dram_data_o);
        for (int h = 0; h < hold; h++) begin
            tick();
            check("ack_single_held", BW'(dram_ack), BW'(0));
        end
        dram_cs = 1'b0;
        if (hold == 0) begin
            tick();
            check("ack_single", BW'(dram_ack), BW'(0));
        end
        tick();
        check("ack_after_release", BW'(dram_ack), BW'(0));
    endtask

    initial begin
        logic [BW-1:0] blk_a;
        logic [BW-1:0] prior;
        bit            saw_ack;
        checks      = 0;
        failures    = 0;
        last_read   = '0;
        rst         = 1'b0;
        dram_cs     = 1'b0;
        dram_we     = 1'b0;
        dram_addr   = '0;
        dram_data_i = '0;

        // Reset state.
        repeat (3) tick();
        check("reset_ack", BW'(dram_ack), BW'(0));
        check("reset_data_o", dram_data_o, '0);
        rst = 1'b1;
        tick();

        // Give every block a known value; high address bits exercise the wrap.
        for (int i = 0; i < DEP; i++) begin
            do_txn(1'b1, {20'($urandom), 8'(i), 4'($urandom)}, rand_block(), 0, 1'b0, 1'b0);
        end

        // Write then read back one block.
        do_txn(1'b1, 32'h0000_0040, 128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_1111_2222, 0, 1'b0, 1'b0);
        do_txn(1'b0, 32'h0000_0040, '0, 0, 1'b0, 1'b0);

        // Index 257 wraps onto block 1.
        blk_a = rand_block();
        do_txn(1'b1, 32'h0000_0010, blk_a, 0, 1'b0, 1'b0);
        do_txn(1'b0, 32'h0000_1010, '0, 0, 1'b0, 1'b0);
        check("wrap_read", dram_data_o, blk_a);

        // A write must not disturb the last read data.
        do_txn(1'b0, 32'h0000_0020, '0, 0, 1'b0, 1'b0);
        do_txn(1'b1, 32'h0000_0030, rand_block(), 0, 1'b0, 1'b0);
        check("hold_after_write", dram_data_o, model_mem[2]);

        // Strobe held well past ack: exactly one ack, next request still taken.
        do_txn(1'b0, 32'h0000_0050, '0, LAT + 3, 1'b0, 1'b0);
        do_txn(1'b0, 32'h0000_0060, '0, 5, 1'b0, 1'b0);

        // Inputs churning during the access do not leak into the request.
        do_txn(1'b1, 32'h0000_0070, rand_block(), 0, 1'b1, 1'b0);
        do_txn(1'b0, 32'h0000_0070, '0, 0, 1'b0, 1'b0);

        // Strobe dropped mid-access still completes.
        do_txn(1'b1, 32'h0000_0090, rand_block(), 0, 1'b0, 1'b1);
        do_txn(1'b0, 32'h0000_0090, '0, 0, 1'b0, 1'b1);

        // Reset in the middle of a write aborts it.
        prior       = model_mem[8];
        dram_cs     = 1'b1;
        dram_we     = 1'b1;
        dram_addr   = 32'h0000_0080;
        dram_data_i = ~prior;
        tick();
        repeat (5) tick();
        rst = 1'b0;
        tick();
        rst     = 1'b1;
        dram_cs = 1'b0;
        check("midreset_ack", BW'(dram_ack), BW'(0));
        check("midreset_data_o", dram_data_o, '0);
        saw_ack = 1'b0;
        for (int c = 0; c < LAT + 3; c++) begin
            tick();
            if (dram_ack === 1'b1) saw_ack = 1'b1;
        end
        check("midreset_no_ack", BW'(saw_ack), BW'(0));
        last_read = '0;
        $display("txn reset_abort addr=00000080");
        do_txn(1'b0, 32'h0000_0080, '0, 0, 1'b0, 1'b0);
        check("midreset_contents", dram_data_o, prior);

        // Random traffic.
        for (int t = 0; t < 60; t++) begin
            do_txn(1'($urandom_range(0, 1)), $urandom, rand_block(),
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dram_responder.md
DRAM_RESPONDER -- requirements
Module: dram_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter BLOCK_WIDTH, default 128, bits per cache block (4 words).
REQ-003 SHALL have parameter DEPTH, default 256, number of blocks stored.
REQ-004 SHALL have parameter LATENCY, default 10, cycles from accept to ack (legal 1..255).
REQ-005 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-007 SHALL have port dram_cs  input  1  request strobe from L1 controller, held until ack.
REQ-008 SHALL have port dram_we  input  1  1 = block write, 0 = block read.
REQ-009 SHALL have port dram_addr  input  ADDR_WIDTH  byte address of block.
REQ-010 SHALL have port dram_data_i  input  BLOCK_WIDTH  write-back block data.
REQ-011 SHALL have port dram_data_o  output  BLOCK_WIDTH  read block data, valid when dram_ack=1.
REQ-012 SHALL have port dram_ack  output  1  one-cycle completion pulse.

Function
REQ-013 SHALL implement states IDLE, ACCESS, ACK, RELEASE.
REQ-014 IDLE: dram_cs=1 at posedge SHALL latch dram_we, dram_addr, dram_data_i, load counter with LATENCY-1, go to ACCESS; else stay IDLE.
REQ-015 ACCESS: counter SHALL decrement each cycle; at counter=0 go to ACK.
REQ-016 Inputs changing during ACCESS SHALL be ignored; only latched values used.
REQ-017 ACK: dram_ack SHALL be 1 for exactly this one cycle; accept-to-ack distance SHALL equal LATENCY cycles.
REQ-018 Write: latched block SHALL be committed to array on entering ACK; read: dram_data_o SHALL present stored block during ACK.
REQ-019 dram_data_o SHALL hold the last read value until the next read completes; writes SHALL not change it.
REQ-020 ACK SHALL go to RELEASE; RELEASE SHALL wait while dram_cs=1 and go to IDLE when dram_cs=0 (no double accept of a held strobe).
REQ-021 Block index SHALL be dram_addr[ADDR_WIDTH-1:4] modulo DEPTH; dram_addr[3:0] ignored; indices beyond DEPTH wrap.
REQ-022 Read after write to same block SHALL return the written data.
REQ-023 dram_cs dropping during ACCESS SHALL not abort; the access completes and acks.
REQ-024 Unknown state encoding SHALL return to IDLE next cycle.

Reset
REQ-025 rst=0 at posedge SHALL force state IDLE, counter 0, dram_ack 0, dram_data_o 0, in any state.
REQ-026 Reset mid-ACCESS SHALL abort the request; a pending write SHALL not be committed.
REQ-027 Array contents SHALL not be cleared by reset.

Structure
REQ-028 State encodings (DRAM_STATE_*) and default LATENCY SHALL be defines in shared StateTable.v alongside cache controller states.
REQ-029 Storage SHALL be sub-module dram_array: single-port, synchronous write, combinational read, DEPTH x BLOCK_WIDTH.
REQ-030 Counter width SHALL be 8 bits.

Verification (LATENCY=10, DEPTH=256)
REQ-031 Write 0xAAAA_BBBB_CCCC_DDDD... to addr 0x0000_0040 at cycle 0 -> dram_ack=1 at cycle 10 only; subsequent read of 0x40 returns same block at its ack.
REQ-032 dram_cs held high 5 cycles past ack -> exactly one ack; next request accepted only after cs low one cycle.
REQ-033 Write block A to 0x0000_0010, then read 0x0000_1010 (index 257 wraps to 1) -> returns A.
REQ-034 rst=0 at cycle 5 of a write to 0x80 -> no ack, outputs 0, later read of 0x80 returns prior contents.
REQ-035 dram_addr/dram_data_i changed every cycle during ACCESS -> committed data and address equal values at accept.
REQ-036 Read of 0x20 then write to 0x30 -> dram_data_o keeps 0x20 block through write ack.
